line_sum_acc_line: RTL and testbench
====================================

// Module: line_sum_acc_line
// PURPOSE
//  Per-frame accumulator stage of the template-matching datapath.
//  - Each clock it adds the current line sums from the line-sum stage to running totals:
//    - sum of I^2
//    - sum of I
//    - one sum of T*I per template
//  - The totals feed the normalisation/correlation stage after NUM_OF_LINES lines.
// PARAMETERS (shared package values)
//  LINE_SIZE      32  pixels per line
//  PIXEL_SIZE      8  bits per pixel
//  NUM_OF_LINES   32  lines per window; sets accumulator headroom
//  NUM_TEMPLATES   4  number of templates (T*I channels)
//  Derived: IN_W  = $clog2(LINE_SIZE)+2*PIXEL_SIZE     (21 at defaults)
//  Derived: ACC_W = $clog2(NUM_OF_LINES)+IN_W          (26 at defaults)
// PORTS
//  CLK                                 in   1                    single clock, rising edge
//  reset                               in   1                    synchronous, active-high; clears all accumulators
//  I_square_out_line_sum               in   IN_W                 current line sum of I^2
//  I_out_line_sum                      in   IN_W                 current line sum of I
//  T_x_I_out_lines_sum                 in   IN_W x NUM_TEMPLATES unpacked array; line sum of T*I per template
//  Acc_lines_sum_I_square              out  ACC_W                running total of I^2 line sums
//  Acc_lines_sum_I                     out  ACC_W                running total of I line sums
//  Acc_lines_sum_T_x_I_out_lines_sum   out  ACC_W x NUM_TEMPLATES unpacked array; running T*I totals
// BEHAVIOUR
//  - One clock (CLK); reset is synchronous and active-high.
//  - All outputs come straight from registers; no combinational path from inputs to outputs.
//  - Reset: at a rising CLK edge with reset=1, every accumulator loads 0.
//    - Inputs present at that edge are discarded, not added.
//    - A reset pulse that is not high at a rising edge has no effect.
//  - Otherwise, at every rising edge: acc <= acc + zero_extend(in), for every channel independently.
//    - No enable or valid: inputs are sampled every cycle.
//    - Upstream drives 0 on idle cycles.
//  - Latency: one cycle. The output after edge k equals the sum of the inputs sampled at edges since the last reset, up to and including edge k.
//  - Width: operands are zero-extended to ACC_W (unsigned).
//    - NUM_OF_LINES full-scale inputs never overflow.
//    - Beyond that, the default is modulo-2^ACC_W wrap-around.
//  - Reset mid-accumulation: totals clear on the reset edge; accumulation restarts from the next edge.
//  - Channels are fully independent; one channel saturating or wrapping never affects another.
//  - Power-up, before the first reset: output values are don't-care. The bench must reset first.
// CONFIGURATION
//  LSA_SATURATE_EN
//   - Defined: each accumulator clamps at 2^ACC_W-1 instead of wrapping.
//     - Computed with an ACC_W+1-bit sum; if the carry bit is set, load all-ones.
//     - Once saturated, it stays saturated until reset.
//   - Undefined: plain modulo-2^ACC_W addition.
// STRUCTURE
//  Package lsa_pkg holds:
//   - LINE_SIZE, PIXEL_SIZE, NUM_OF_LINES, NUM_TEMPLATES
//   - localparams IN_W and ACC_W
//   - typedefs in_t = logic[IN_W-1:0], acc_t = logic[ACC_W-1:0]
//  Sub-module lsa_acc_cell: one parameterised accumulator register.
//   - Ports: CLK, reset, in, acc.
//   - Contains the LSA_SATURATE_EN logic.
//   - The top instantiates it for the I^2 and I channels, plus a generate loop of NUM_TEMPLATES cells for T*I.
// TESTING
//  1 Reset held across one edge -> every output is 0 on the following cycle.
//  2 After reset, I^2 = 10, 20, 30 over 3 edges -> Acc_lines_sum_I_square = 10, 30, 60.
//    - Same check on I with 5, 7, 9 -> 5, 12, 21.
//  3 Templates: per-template inputs j*10+1 for 4 cycles -> template j total = 4*(j*10+1): 4, 44, 84, 124.
//    - No cross-talk between templates.
//  4 Reset asserted mid-stream after totals reach 60 -> 0 after the reset edge.
//    - Next input 255 -> 255.
//  5 NUM_OF_LINES (32) cycles of all-ones input (2^21-1) -> 32*(2^21-1) = 67108832, no overflow.
//  6 Overflow: keep feeding 2^21-1 past 32 cycles.
//    - Without LSA_SATURATE_EN: total wraps modulo 2^26.
//    - With LSA_SATURATE_EN: holds at 2^26-1 = 67108863.
//  Random regression: compare against a reference model summing 0..255 random inputs over 10 cycles, with one reset in the middle.

Source files
------------

// File: rtl/lsa_pkg.sv
// rtl/lsa_pkg.sv - shared sizes and types for the line-sum accumulator stage
package lsa_pkg;

   localparam int LINE_SIZE     = 32;
   localparam int PIXEL_SIZE    = 8;
   localparam int NUM_OF_LINES  = 32;
   localparam int NUM_TEMPLATES = 4;

   // One line sum of products needs log2(pixels) bits of headroom above a pixel product
   localparam int IN_W  = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
   // A window total needs log2(lines) bits of headroom above a line sum
   localparam int ACC_W = $clog2(NUM_OF_LINES) + IN_W;

   typedef logic [IN_W-1:0]  in_t;
   typedef logic [ACC_W-1:0] acc_t;

endpackage

// File: rtl/lsa_acc_cell.sv
// rtl/lsa_acc_cell.sv - one running-total register (saturating when LSA_SATURATE_EN is defined)
module lsa_acc_cell
   import lsa_pkg::*;
#(
   parameter int CELL_IN_W  = IN_W,
   parameter int CELL_ACC_W = ACC_W
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic [CELL_IN_W-1:0]  in,
   output logic [CELL_ACC_W-1:0] acc
);

   logic [CELL_ACC_W-1:0] in_ext;
   logic [CELL_ACC_W-1:0] acc_nxt;

   // Unsigned operand, widened to the accumulator width
   assign in_ext = {{(CELL_ACC_W - CELL_IN_W){1'b0}}, in};

`ifdef LSA_SATURATE_EN
   logic [CELL_ACC_W:0] sum_wide;

   // Carry out of the wide sum means the total no longer fits: pin it at all-ones.
   // Once pinned, any further add either carries or adds zero, so it stays pinned.
   always_comb begin
      sum_wide = {1'b0, acc} + {1'b0, in_ext};
      acc_nxt  = sum_wide[CELL_ACC_W] ? {CELL_ACC_W{1'b1}} : sum_wide[CELL_ACC_W-1:0];
   end
`else
   // Plain modulo-2^ACC_W addition
   always_comb begin
      acc_nxt = acc + in_ext;
   end
`endif

   // Running total; reset discards the input sampled on the same edge
   always_ff @(posedge CLK) begin
      if (reset) begin
         acc <= '0;
      end else begin
         acc <= acc_nxt;
      end
   end

endmodule

// File: rtl/line_sum_acc_line.sv
// rtl/line_sum_acc_line.sv - per-frame accumulation of I^2, I and T*I line sums (option: LSA_SATURATE_EN)
module line_sum_acc_line
   import lsa_pkg::*;
(
   input  logic CLK,
   input  logic reset,
   input  in_t  I_square_out_line_sum,
   input  in_t  I_out_line_sum,
   input  in_t  T_x_I_out_lines_sum [NUM_TEMPLATES],
   output acc_t Acc_lines_sum_I_square,
   output acc_t Acc_lines_sum_I,
   output acc_t Acc_lines_sum_T_x_I_out_lines_sum [NUM_TEMPLATES]
);

   // Sum of I^2 over the window
   lsa_acc_cell #(.CELL_IN_W(IN_W), .CELL_ACC_W(ACC_W)) u_acc_i_square (
      .CLK   (CLK),
      .reset (reset),
      .in    (I_square_out_line_sum),
      .acc   (Acc_lines_sum_I_square)
   );

   // Sum of I over the window
   lsa_acc_cell #(.CELL_IN_W(IN_W), .CELL_ACC_W(ACC_W)) u_acc_i (
      .CLK   (CLK),
      .reset (reset),
      .in    (I_out_line_sum),
      .acc   (Acc_lines_sum_I)
   );

   // One independent T*I total per template
   for (genvar j = 0; j < NUM_TEMPLATES; j++) begin : g_tmpl
      lsa_acc_cell #(.CELL_IN_W(IN_W), .CELL_ACC_W(ACC_W)) u_acc_t_x_i (
         .CLK   (CLK),
         .reset (reset),
         .in    (T_x_I_out_lines_sum[j]),
         .acc   (Acc_lines_sum_T_x_I_out_lines_sum[j])
      );
   end

endmodule

// File: tb/tb_line_sum_acc_line.sv
// tb/tb_line_sum_acc_line.sv - scoreboard bench for line_sum_acc_line (expectations follow LSA_SATURATE_EN)
module tb_line_sum_acc_line;
   import lsa_pkg::*;

   typedef logic [NUM_TEMPLATES-1:0][IN_W-1:0]  tin_t;
   typedef logic [NUM_TEMPLATES-1:0][ACC_W-1:0] tacc_t;

   typedef struct packed {
      acc_t  x_i2;
      acc_t  x_i;
      tacc_t x_t;
   } exp_t;

   localparam in_t  ALL_ONES_IN = in_t'((1 << IN_W) - 1);
   localparam acc_t FULL_WIN    = acc_t'(67108832);

   logic clk;
   logic reset;
   in_t  i2_in;
   in_t  i_in;
   in_t  t_in   [NUM_TEMPLATES];
   acc_t acc_i2;
   acc_t acc_i;
   acc_t acc_t_o [NUM_TEMPLATES];

   exp_t sb[$];
   int   n_checks;
   int   n_fail;

   longint m_i2, m_i;
   longint m_t [NUM_TEMPLATES];

   line_sum_acc_line dut (
      .CLK                               (clk),
      .reset                             (reset),
      .I_square_out_line_sum             (i2_in),
      .I_out_line_sum                    (i_in),
      .T_x_I_out_lines_sum               (t_in),
      .Acc_lines_sum_I_square            (acc_i2),
      .Acc_lines_sum_I                   (acc_i),
      .Acc_lines_sum_T_x_I_out_lines_sum (acc_t_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic tin_t mk_t(input int a0, input int a1, input int a2, input int a3);
      tin_t r;
      r[0] = in_t'(a0); r[1] = in_t'(a1); r[2] = in_t'(a2); r[3] = in_t'(a3);
      return r;
   endfunction

   function automatic tacc_t mk_x(input longint a0, input longint a1, input longint a2, input longint a3);
      tacc_t r;
      r[0] = acc_t'(a0); r[1] = acc_t'(a1); r[2] = acc_t'(a2); r[3] = acc_t'(a3);
      return r;
   endfunction

   // Drive one edge's worth of inputs and queue the outputs expected after that edge
   task automatic step(input bit rst, input in_t v_i2, input in_t v_i, input tin_t v_t,
                       input acc_t x_i2, input acc_t x_i, input tacc_t x_t);
      exp_t e;
      @(negedge clk);
      reset = rst;
      i2_in = v_i2;
      i_in  = v_i;
      for (int j = 0; j < NUM_TEMPLATES; j++) t_in[j] = v_t[j];
      e.x_i2 = x_i2;
      e.x_i  = x_i;
      e.x_t  = x_t;
      sb.push_back(e);
   endtask

   // Monitor: one queued expectation per rising edge, compared just after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("acc_i_square", acc_i2, e.x_i2);
            check("acc_i", acc_i, e.x_i);
            for (int j = 0; j < NUM_TEMPLATES; j++)
               check($sformatf("acc_t_x_i[%0d]", j), acc_t_o[j], e.x_t[j]);
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tin_t   rt;
      in_t    r2, r1;
      acc_t   wrap1, wrap2;
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      i2_in    = '0;
      i_in     = '0;
      for (int j = 0; j < NUM_TEMPLATES; j++) t_in[j] = '0;

      // 1: reset edge discards the inputs presented with it
      step(1, 99, 99, mk_t(99, 99, 99, 99), 0, 0, mk_x(0, 0, 0, 0));

      // 2: I^2 10,20,30 and I 5,7,9
      step(0, 10, 5, mk_t(0, 0, 0, 0), 10, 5,  mk_x(0, 0, 0, 0));
      step(0, 20, 7, mk_t(0, 0, 0, 0), 30, 12, mk_x(0, 0, 0, 0));
      step(0, 30, 9, mk_t(0, 0, 0, 0), 60, 21, mk_x(0, 0, 0, 0));

      // 3: template j gets j*10+1 for four cycles, other channels idle
      step(0, 0, 0, mk_t(1, 11, 21, 31), 60, 21, mk_x(1, 11, 21, 31));
      step(0, 0, 0, mk_t(1, 11, 21, 31), 60, 21, mk_x(2, 22, 42, 62));
      step(0, 0, 0, mk_t(1, 11, 21, 31), 60, 21, mk_x(3, 33, 63, 93));
      step(0, 0, 0, mk_t(1, 11, 21, 31), 60, 21, mk_x(4, 44, 84, 124));

      // 4: a reset glitch between edges changes nothing
      step(0, 0, 0, mk_t(0, 0, 0, 0), 60, 21, mk_x(4, 44, 84, 124));
      #1 reset = 1'b1;
      #2 reset = 1'b0;
      step(0, 0, 0, mk_t(0, 0, 0, 0), 60, 21, mk_x(4, 44, 84, 124));
      // reset mid-stream clears, then accumulation restarts
      step(1, 7, 7, mk_t(7, 7, 7, 7), 0, 0, mk_x(0, 0, 0, 0));
      step(0, 255, 255, mk_t(255, 255, 255, 255), 255, 255, mk_x(255, 255, 255, 255));

      // 5: full window of full-scale line sums
      step(1, 0, 0, mk_t(0, 0, 0, 0), 0, 0, mk_x(0, 0, 0, 0));
      for (int k = 1; k <= NUM_OF_LINES; k++) begin
         longint s;
         s = longint'(k) * 2097151;
         step(0, ALL_ONES_IN, ALL_ONES_IN,
              mk_t(2097151, 2097151, 2097151, 2097151),
              acc_t'(s), acc_t'(s), mk_x(s, s, s, s));
      end
      check("full_window_constant", sb[$].x_i2, 67108832);
      check("full_window_no_overflow", FULL_WIN, longint'(NUM_OF_LINES) * 2097151);

      // 6: past the window
`ifdef LSA_SATURATE_EN
      wrap1 = acc_t'(67108863);
      wrap2 = acc_t'(67108863);
`else
      wrap1 = acc_t'(2097119);
      wrap2 = acc_t'(4194270);
`endif
      step(0, ALL_ONES_IN, ALL_ONES_IN, mk_t(2097151, 2097151, 2097151, 2097151),
           wrap1, wrap1, mk_x(wrap1, wrap1, wrap1, wrap1));
      // only I^2 keeps feeding; the other channels must hold their own values
      step(0, ALL_ONES_IN, 0, mk_t(0, 0, 0, 0),
           wrap2, wrap1, mk_x(wrap1, wrap1, wrap1, wrap1));

      // Random regression against a running-sum reference, with a reset in the middle
      step(1, 0, 0, mk_t(0, 0, 0, 0), 0, 0, mk_x(0, 0, 0, 0));
      m_i2 = 0; m_i = 0;
      for (int j = 0; j < NUM_TEMPLATES; j++) m_t[j] = 0;
      for (int k = 0; k < 10; k++) begin
         bit rst;
         rst = (k == 5);
         r2 = in_t'($urandom_range(255));
         r1 = in_t'($urandom_range(255));
         for (int j = 0; j < NUM_TEMPLATES; j++) rt[j] = in_t'($urandom_range(255));
         if (rst) begin
            m_i2 = 0; m_i = 0;
            for (int j = 0; j < NUM_TEMPLATES; j++) m_t[j] = 0;
         end else begin
            m_i2 += r2; m_i += r1;
            for (int j = 0; j < NUM_TEMPLATES; j++) m_t[j] += rt[j];
         end
         step(rst, r2, r1, rt, acc_t'(m_i2), acc_t'(m_i),
              mk_x(m_t[0], m_t[1], m_t[2], m_t[3]));
      end

      @(negedge clk);
      reset = 1'b0;
      i2_in = '0;
      i_in  = '0;
      for (int j = 0; j < NUM_TEMPLATES; j++) t_in[j] = '0;
      @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
